// File: rtl/sap_obi_to_axi_master.sv
// OBI manager port to single-beat AXI4 manager bridge with in-order response return.
// Optional sticky error interrupt (err_irq_o/err_clr_i) enabled by defining SAP_OBI2AXI_ERR_IRQ_EN.
module sap_obi_to_axi_master #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned AxiId          = 0,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   obi_req_i,
    output logic                   obi_gnt_o,
    input  logic [AddrWidth-1:0]   obi_addr_i,
    input  logic                   obi_we_i,
    input  logic [DataWidth/8-1:0] obi_be_i,
    input  logic [DataWidth-1:0]   obi_wdata_i,
    output logic                   obi_rvalid_o,
    output logic [DataWidth-1:0]   obi_rdata_o,
    output logic                   obi_err_o,
`ifdef SAP_OBI2AXI_ERR_IRQ_EN
    output logic                   err_irq_o,
    input  logic                   err_clr_i,
`endif
    output logic                   axi_awvalid_o,
    input  logic                   axi_awready_i,
    output logic [AddrWidth-1:0]   axi_awaddr_o,
    output logic [IdWidth-1:0]     axi_awid_o,
    output logic [7:0]             axi_awlen_o,
    output logic [2:0]             axi_awsize_o,
    output logic [1:0]             axi_awburst_o,
    output logic [2:0]             axi_awprot_o,
    output logic [3:0]             axi_awcache_o,
    output logic                   axi_awlock_o,
    output logic [3:0]             axi_awqos_o,
    output logic                   axi_wvalid_o,
    input  logic                   axi_wready_i,
    output logic [DataWidth-1:0]   axi_wdata_o,
    output logic [DataWidth/8-1:0] axi_wstrb_o,
    output logic                   axi_wlast_o,
    input  logic                   axi_bvalid_i,
    output logic                   axi_bready_o,
    input  logic [1:0]             axi_bresp_i,
    input  logic [IdWidth-1:0]     axi_bid_i,
    output logic                   axi_arvalid_o,
    input  logic                   axi_arready_i,
    output logic [AddrWidth-1:0]   axi_araddr_o,
    output logic [IdWidth-1:0]     axi_arid_o,
    output logic [7:0]             axi_arlen_o,
    output logic [2:0]             axi_arsize_o,
    output logic [1:0]             axi_arburst_o,
    output logic [2:0]             axi_arprot_o,
    output logic [3:0]             axi_arcache_o,
    output logic                   axi_arlock_o,
    output logic [3:0]             axi_arqos_o,
    input  logic                   axi_rvalid_i,
    output logic                   axi_rready_o,
    input  logic [DataWidth-1:0]   axi_rdata_i,
    input  logic [1:0]             axi_rresp_i,
    input  logic                   axi_rlast_i,
    input  logic [IdWidth-1:0]     axi_rid_i
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned PtrWidth  = $clog2(MaxOutstanding);
    localparam int unsigned CntWidth  = PtrWidth + 1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StIssueWr = 2'd1;
    localparam logic [1:0] StIssueRd = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [StrbWidth-1:0] strb_q, strb_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 arvalid_q, arvalid_d;

    logic [MaxOutstanding-1:0] fifo_q;
    logic [PtrWidth-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]       cnt_q;

    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [DataWidth-1:0] rsp_data_q;

    logic fifo_empty_c, fifo_full_c, head_c;
    logic b_hs_c, r_hs_c, pop_c, gnt_c, rsp_err_c;

    // Response ordering: the FIFO head says which channel may complete next.
    assign fifo_empty_c = (cnt_q == '0);
    assign head_c       = fifo_q[rd_ptr_q];
    assign axi_bready_o = !fifo_empty_c && head_c;
    assign axi_rready_o = !fifo_empty_c && !head_c;
    assign b_hs_c       = axi_bvalid_i && axi_bready_o;
    assign r_hs_c       = axi_rvalid_i && axi_rready_o;
    assign pop_c        = b_hs_c || r_hs_c;
    assign rsp_err_c    = b_hs_c ? axi_bresp_i[1] : axi_rresp_i[1];
    // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
    assign fifo_full_c  = (cnt_q == CntWidth'(MaxOutstanding)) && !pop_c;
    assign gnt_c        = obi_req_i && (state_q == StIdle) && !fifo_full_c;
    assign obi_gnt_o    = gnt_c;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        strb_d    = strb_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        case (state_q)
            StIdle: begin
                if (gnt_c) begin
                    addr_d  = obi_addr_i;
                    strb_d  = obi_be_i;
                    wdata_d = obi_wdata_i;
                    if (obi_we_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StIssueWr;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StIssueRd;
                    end
                end
            end
            StIssueWr: begin
                if (axi_awready_i) awvalid_d = 1'b0;
                if (axi_wready_i)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = StIdle;
            end
            StIssueRd: begin
                if (axi_arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
        end
    end

    // Order FIFO: one type bit per transaction (1 = write).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (gnt_c) begin
                fifo_q[wr_ptr_q] <= obi_we_i;
                wr_ptr_q         <= wr_ptr_q + PtrWidth'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            if (gnt_c && !pop_c)      cnt_q <= cnt_q + CntWidth'(1);
            else if (!gnt_c && pop_c) cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= pop_c;
            if (pop_c) begin
                rsp_err_q  <= rsp_err_c;
                rsp_data_q <= b_hs_c ? '0 : axi_rdata_i;
            end
        end
    end

`ifdef SAP_OBI2AXI_ERR_IRQ_EN
    logic err_irq_q;

    // Sticky error flag; a new error outranks a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                 err_irq_q <= 1'b0;
        else if (pop_c && rsp_err_c) err_irq_q <= 1'b1;
        else if (err_clr_i)          err_irq_q <= 1'b0;
    end
    assign err_irq_o = err_irq_q;
`endif

    // Single fixed ID and single-beat bursts make these inputs irrelevant.
    logic unused_c;
    assign unused_c = ^{axi_bid_i, axi_rid_i, axi_rlast_i, axi_bresp_i[0], axi_rresp_i[0]};

    assign obi_rvalid_o  = rsp_valid_q;
    assign obi_rdata_o   = rsp_data_q;
    assign obi_err_o     = rsp_err_q;

    assign axi_awvalid_o = awvalid_q;
    assign axi_awaddr_o  = addr_q;
    assign axi_awid_o    = IdWidth'(AxiId);
    assign axi_awlen_o   = 8'd0;
    assign axi_awsize_o  = 3'b010;
    assign axi_awburst_o = 2'b01;
    assign axi_awprot_o  = 3'b000;
    assign axi_awcache_o = 4'b0010;
    assign axi_awlock_o  = 1'b0;
    assign axi_awqos_o   = 4'd0;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = strb_q;
    assign axi_wlast_o   = 1'b1;
    assign axi_arvalid_o = arvalid_q;
    assign axi_araddr_o  = addr_q;
    assign axi_arid_o    = IdWidth'(AxiId);
    assign axi_arlen_o   = 8'd0;
    assign axi_arsize_o  = 3'b010;
    assign axi_arburst_o = 2'b01;
    assign axi_arprot_o  = 3'b000;
    assign axi_arcache_o = 4'b0010;
    assign axi_arlock_o  = 1'b0;
    assign axi_arqos_o   = 4'd0;

endmodule
